uart_prog_loader: RTL

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Boot-time program loader. Consumes a framed word stream from a UART receiver
// and writes the payload into instruction memory while holding the CPU in
// reset. Frame layout: MAGIC, N, N data words, checksum (mod-2^DBIT sum of the
// data words). A good checksum releases the CPU; any framing problem (bad N,
// bad checksum, inter-word timeout) parks the loader in an error state with
// the CPU still held. A fresh MAGIC in either end state starts a new load.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   rx_done_tick  in   one-cycle strobe, rx_dout carries a new word
//   rx_dout       in   [DBIT-1:0] received word
//   mem_we        out  registered one-cycle memory write strobe
//   mem_addr      out  [ADDR_W-1:0] registered write word address
//   mem_wdata     out  [DBIT-1:0] registered write data
//   cpu_hold      out  1 keeps the CPU in reset
//   load_done     out  last transfer completed with a good checksum
//   load_err      out  last transfer aborted
// -----------------------------------------------------------------------------
module uart_prog_loader #(
   parameter int unsigned     DBIT        = 32,
   parameter int unsigned     ADDR_W      = 10,
   parameter int unsigned     TIMEOUT_CYC = 1_000_000,
   parameter logic [DBIT-1:0] MAGIC       = 32'hB007_10AD
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rx_done_tick,
   input  logic [DBIT-1:0]   rx_dout,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DBIT-1:0]   mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err
);

   // Width wide enough to compare a received count against 2^ADDR_W without
   // truncating either side.
   localparam int unsigned CW = (DBIT > ADDR_W + 1) ? DBIT : ADDR_W + 1;
   localparam logic [CW-1:0] CAP = CW'(1) << ADDR_W;

   // Timer counts idle clocks 0 .. TIMEOUT_CYC-1; the clock on which it sits
   // at TIMEOUT_CYC-1 with no tick is the TIMEOUT_CYC-th silent clock.
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCount,
      StData,
      StCsum,
      StDone,
      StError
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   remaining;
   logic [DBIT-1:0]   sum;
   logic [TW-1:0]     tmr;

   logic          in_xfer;
   logic          expired;
   logic          is_magic;
   logic [CW-1:0] n_word;
   logic          n_ok;

   assign in_xfer  = (state == StCount) || (state == StData) || (state == StCsum);
   // A tick on the expiry clock wins: the word is consumed instead.
   assign expired  = in_xfer && !rx_done_tick && (tmr == TMR_LAST);
   assign is_magic = (rx_dout == MAGIC);
   assign n_word   = CW'(rx_dout);
   assign n_ok     = (n_word != '0) && (n_word <= CAP);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= StIdle;
         idx       <= '0;
         remaining <= '0;
         sum       <= '0;
         tmr       <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_hold  <= 1'b1;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         mem_we <= 1'b0;

         if (rx_done_tick || !in_xfer || expired) begin
            tmr <= '0;
         end else begin
            tmr <= tmr + TW'(1);
         end

         unique case (state)
            StIdle: begin
               if (rx_done_tick && is_magic) begin
                  state <= StCount;
               end
            end

            StCount: begin
               if (rx_done_tick) begin
                  if (n_ok) begin
                     remaining <= n_word[ADDR_W:0];
                     idx       <= '0;
                     sum       <= '0;
                     state     <= StData;
                  end else begin
                     state    <= StError;
                     cpu_hold <= 1'b1;
                     load_err <= 1'b1;
                  end
               end else if (expired) begin
                  state    <= StError;
                  cpu_hold <= 1'b1;
                  load_err <= 1'b1;
               end
            end

            StData: begin
               if (rx_done_tick) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= idx;
                  mem_wdata <= rx_dout;
                  // Index may wrap to 0 after address 2^ADDR_W-1, but the FSM
                  // has already left DATA by then so no further write happens.
                  idx       <= idx + ADDR_W'(1);
                  sum       <= sum + rx_dout;
                  remaining <= remaining - (ADDR_W + 1)'(1);
                  if (remaining == (ADDR_W + 1)'(1)) begin
                     state <= StCsum;
                  end
               end else if (expired) begin
                  state    <= StError;
                  cpu_hold <= 1'b1;
                  load_err <= 1'b1;
               end
            end

            StCsum: begin
               if (rx_done_tick) begin
                  if (rx_dout == sum) begin
                     state     <= StDone;
                     cpu_hold  <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     state    <= StError;
                     cpu_hold <= 1'b1;
                     load_err <= 1'b1;
                  end
               end else if (expired) begin
                  state    <= StError;
                  cpu_hold <= 1'b1;
                  load_err <= 1'b1;
               end
            end

            StDone, StError: begin
               if (rx_done_tick && is_magic) begin
                  state     <= StCount;
                  cpu_hold  <= 1'b1;
                  load_done <= 1'b0;
                  load_err  <= 1'b0;
               end
            end

            default: begin
               state    <= StError;
               cpu_hold <= 1'b1;
               load_err <= 1'b1;
            end
         endcase
      end
   end

endmodule
